// File: rtl/word_serializer_32_bit_if.sv
// Word handshake bundle for the serializer.
// Source side drives the word and valid, sink answers with ready.
interface word_serializer_32_bit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] Word_In;
    logic                  Word_Valid_In;
    logic                  Word_Ready_Out;

    modport master (
        output Word_In,
        output Word_Valid_In,
        input  Word_Ready_Out
    );

    modport slave (
        input  Word_In,
        input  Word_Valid_In,
        output Word_Ready_Out
    );
endinterface

// File: rtl/word_serializer_32_bit.sv
// Parallel-to-serial transmit stage feeding the SISO shift register.
// One word per handshake, one strobe per bit, optional inter-word gap.
module word_serializer_32_bit #(
    parameter int DATA_WIDTH = 32,
    parameter int BIT_PERIOD = 1,
    parameter int GAP_CYCLES = 0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic Clk_In,
    input  logic Reset_In,
    input  logic Enable_In,
    word_serializer_32_bit_if.slave word_bus,
    output logic Serial_Data_Out,
    output logic Shift_Data_Signal_Out,
    output logic Busy_Out,
    output logic Word_Done_Out
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(BIT_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [PW-1:0]         per_cnt_q;
    logic [GW-1:0]         gap_cnt_q;
    logic                  sdo_q;
    logic                  done_q;

    logic per_last;
    logic bit_last;
    logic gap_last;
    logic first_bit;
    logic next_bit;
    logic [DATA_WIDTH-1:0] shreg_next;

    assign per_last = (per_cnt_q == PER_LAST);
    assign bit_last = (bit_cnt_q == '0);
    assign gap_last = (gap_cnt_q == GAP_LAST);

    // The output end of the register is the MSB or LSB depending on order.
    always_comb begin
        first_bit  = word_bus.Word_In[0];
        next_bit   = shreg_q[1];
        shreg_next = {1'b0, shreg_q[DATA_WIDTH-1:1]};
        if (MSB_FIRST) begin
            first_bit  = word_bus.Word_In[DATA_WIDTH-1];
            next_bit   = shreg_q[DATA_WIDTH-2];
            shreg_next = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Enable_In) begin
            case (state_q)
                S_IDLE: begin
                    if (word_bus.Word_Valid_In) begin
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (per_last && bit_last) begin
                        state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Ready is held low while reset is asserted so it rises only after.
    always_comb begin
        word_bus.Word_Ready_Out = (state_q == S_IDLE) && Enable_In && !Reset_In;
        Shift_Data_Signal_Out   = (state_q == S_SHIFT) && per_last && Enable_In;
        Busy_Out                = (state_q != S_IDLE);
        Word_Done_Out           = done_q && Enable_In;
        Serial_Data_Out         = sdo_q;
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            per_cnt_q <= '0;
            gap_cnt_q <= '0;
            sdo_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (Enable_In) begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (word_bus.Word_Valid_In) begin
                        shreg_q   <= word_bus.Word_In;
                        bit_cnt_q <= BIT_LAST;
                        per_cnt_q <= '0;
                        sdo_q     <= first_bit;
                    end
                end
                S_SHIFT: begin
                    if (!per_last) begin
                        per_cnt_q <= per_cnt_q + 1'b1;
                    end else if (!bit_last) begin
                        shreg_q   <= shreg_next;
                        sdo_q     <= next_bit;
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        per_cnt_q <= '0;
                    end else begin
                        sdo_q     <= 1'b0;
                        done_q    <= 1'b1;
                        per_cnt_q <= '0;
                        gap_cnt_q <= '0;
                    end
                end
                S_GAP: begin
                    if (!gap_last) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    sdo_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_serializer_32_bit.sv
// Directed bench for word_serializer_32_bit.
// Table of words plus hand-written multi-cycle sequences.
module tb_word_serializer_32_bit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, en1, sdo1, stb1, busy1, done1;
    logic rst2, en2, sdo2, stb2, busy2, done2;

    word_serializer_32_bit_if #(.DATA_WIDTH(32)) bus1 ();
    word_serializer_32_bit_if #(.DATA_WIDTH(32)) bus2 ();

    word_serializer_32_bit #(
        .DATA_WIDTH(32), .BIT_PERIOD(1), .GAP_CYCLES(0), .MSB_FIRST(1'b1)
    ) dut1 (
        .Clk_In(clk), .Reset_In(rst1), .Enable_In(en1), .word_bus(bus1),
        .Serial_Data_Out(sdo1), .Shift_Data_Signal_Out(stb1),
        .Busy_Out(busy1), .Word_Done_Out(done1)
    );

    word_serializer_32_bit #(
        .DATA_WIDTH(32), .BIT_PERIOD(3), .GAP_CYCLES(2), .MSB_FIRST(1'b1)
    ) dut2 (
        .Clk_In(clk), .Reset_In(rst2), .Enable_In(en2), .word_bus(bus2),
        .Serial_Data_Out(sdo2), .Shift_Data_Signal_Out(stb2),
        .Busy_Out(busy2), .Word_Done_Out(done2)
    );

    typedef struct {
        logic [31:0] word;
        logic [3:0]  first4;
        logic [3:0]  last4;
    } vec_t;

    vec_t tbl [4];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Sends one word on dut1; hold_len cycles of Enable_In low from hold_at.
    task automatic run_word1(input logic [31:0] w, input int hold_at,
                             input int hold_len, input bit toggle,
                             output logic [31:0] siso, output int nstb,
                             output int berr, output int dcyc,
                             output int xrdy);
        int eff;
        int idx;
        logic es, estb;
        siso = '0; nstb = 0; berr = 0; dcyc = -1; xrdy = 0;
        en1 = 1'b1;
        bus1.Word_In = w;
        bus1.Word_Valid_In = 1'b1;
        #1;
        chk("accept_ready", {31'b0, bus1.Word_Ready_Out}, 32'd1);
        step;
        for (int c = 1; c <= 80; c++) begin
            bus1.Word_Valid_In = toggle;
            if (toggle) bus1.Word_In = ~w ^ 32'(c);
            en1 = !(hold_len > 0 && c >= hold_at && c < hold_at + hold_len);
            #1;
            es = 1'b0;
            estb = 1'b0;
            if (!en1) begin
                idx = 32 - hold_at;
                es = w[idx];
            end else begin
                eff = (hold_len > 0 && c >= hold_at + hold_len) ? c - hold_len : c;
                if (eff >= 1 && eff <= 32) begin
                    idx = 32 - eff;
                    es = w[idx];
                    estb = 1'b1;
                end
            end
            if (sdo1 !== es || stb1 !== estb) berr++;
            if (stb1 === 1'b1) begin
                nstb++;
                siso = {siso[30:0], sdo1};
            end
            if (bus1.Word_Ready_Out === 1'b1 && done1 !== 1'b1) xrdy++;
            if (done1 === 1'b1) begin
                dcyc = c;
                break;
            end
            step;
        end
        bus1.Word_Valid_In = 1'b0;
        en1 = 1'b1;
    endtask

    logic [31:0] siso, s2, s2a, w2;
    logic e_s, e_stb, e_rdy, e_done;
    int nstb, berr, dcyc, xrdy;
    int acc2, d1, d2, err2, t, idx2;

    initial begin
        tbl[0] = '{32'hA5C3_0F81, 4'hA, 4'h1};
        tbl[1] = '{32'h8765_4321, 4'h8, 4'h1};
        tbl[2] = '{32'hFFFF_0000, 4'hF, 4'h0};
        tbl[3] = '{32'h0000_0001, 4'h0, 4'h1};

        rst1 = 1'b1; rst2 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        bus1.Word_In = '0; bus1.Word_Valid_In = 1'b0;
        bus2.Word_In = '0; bus2.Word_Valid_In = 1'b0;
        step;
        step;
        chk("rst_ready", {31'b0, bus1.Word_Ready_Out}, 32'd0);
        chk("rst_sdo", {31'b0, sdo1}, 32'd0);
        chk("rst_stb", {31'b0, stb1}, 32'd0);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        chk("rst_done", {31'b0, done1}, 32'd0);
        rst1 = 1'b0; rst2 = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, bus1.Word_Ready_Out}, 32'd1);
        chk("post_rst_sdo", {31'b0, sdo1}, 32'd0);
        chk("post_rst_busy", {31'b0, busy1}, 32'd0);
        chk("post_rst_ready2", {31'b0, bus2.Word_Ready_Out}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            run_word1(tbl[i].word, 0, 0, 1'b0, siso, nstb, berr, dcyc, xrdy);
            chk("tbl_siso", siso, tbl[i].word);
            chk("tbl_first4", {28'b0, siso[31:28]}, {28'b0, tbl[i].first4});
            chk("tbl_last4", {28'b0, siso[3:0]}, {28'b0, tbl[i].last4});
            chk("tbl_strobes", nstb, 32);
            chk("tbl_bits", berr, 0);
            chk("tbl_done_cycle", dcyc, 33);
            chk("tbl_extra_ready", xrdy, 0);
        end

        run_word1(32'hA5C3_0F81, 11, 5, 1'b0, siso, nstb, berr, dcyc, xrdy);
        chk("hold_siso", siso, 32'hA5C3_0F81);
        chk("hold_strobes", nstb, 32);
        chk("hold_bits", berr, 0);
        chk("hold_done_cycle", dcyc, 38);
        chk("hold_ready", xrdy, 0);

        run_word1(32'h3C5A_96E1, 0, 0, 1'b1, siso, nstb, berr, dcyc, xrdy);
        chk("toggle_siso", siso, 32'h3C5A_96E1);
        chk("toggle_strobes", nstb, 32);
        chk("toggle_bits", berr, 0);
        chk("toggle_extra_accept", xrdy, 0);

        bus1.Word_In = 32'h1234_5678;
        bus1.Word_Valid_In = 1'b1;
        #1;
        chk("mid_rst_accept", {31'b0, bus1.Word_Ready_Out}, 32'd1);
        step;
        bus1.Word_Valid_In = 1'b0;
        for (int c = 1; c < 8; c++) step;
        chk("mid_rst_busy", {31'b0, busy1}, 32'd1);
        rst1 = 1'b1;
        step;
        chk("in_rst_ready", {31'b0, bus1.Word_Ready_Out}, 32'd0);
        rst1 = 1'b0;
        #1;
        chk("after_rst_busy", {31'b0, busy1}, 32'd0);
        chk("after_rst_sdo", {31'b0, sdo1}, 32'd0);
        chk("after_rst_done", {31'b0, done1}, 32'd0);
        chk("after_rst_stb", {31'b0, stb1}, 32'd0);
        chk("after_rst_ready", {31'b0, bus1.Word_Ready_Out}, 32'd1);
        run_word1(32'h8765_4321, 0, 0, 1'b0, siso, nstb, berr, dcyc, xrdy);
        chk("after_rst_siso", siso, 32'h8765_4321);
        chk("after_rst_bits", berr, 0);
        chk("after_rst_done_cycle", dcyc, 33);

        acc2 = -1; d1 = -1; d2 = -1; err2 = 0; s2 = '0; s2a = '0;
        bus2.Word_In = 32'hFFFF_0000;
        bus2.Word_Valid_In = 1'b1;
        #1;
        chk("p3_accept", {31'b0, bus2.Word_Ready_Out}, 32'd1);
        step;
        bus2.Word_In = 32'h0000_0001;
        for (int c = 1; c <= 198; c++) begin
            if (c >= 100) bus2.Word_Valid_In = 1'b0;
            #1;
            t = (c > 99) ? c - 99 : c;
            w2 = (c > 99) ? 32'h0000_0001 : 32'hFFFF_0000;
            e_stb = (t >= 1 && t <= 96 && (t % 3) == 0);
            e_s = 1'b0;
            if (t >= 1 && t <= 96) begin
                idx2 = 31 - (t - 1) / 3;
                e_s = w2[idx2];
            end
            e_rdy = (t == 99);
            e_done = (t == 97);
            if (stb2 !== e_stb || sdo2 !== e_s) err2++;
            if (bus2.Word_Ready_Out !== e_rdy || done2 !== e_done) err2++;
            if (stb2 === 1'b1) s2 = {s2[30:0], sdo2};
            if (c == 97) s2a = s2;
            if (bus2.Word_Ready_Out === 1'b1 && bus2.Word_Valid_In === 1'b1 && acc2 < 0)
                acc2 = c;
            if (done2 === 1'b1) begin
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            if (c == 98) begin
                chk("p3_gap_busy", {31'b0, busy2}, 32'd1);
                chk("p3_gap_sdo", {31'b0, sdo2}, 32'd0);
            end
            step;
        end
        chk("p3_cycle_trace", err2, 0);
        chk("p3_second_accept", acc2, 99);
        chk("p3_first_word", s2a, 32'hFFFF_0000);
        chk("p3_second_word", s2, 32'h0000_0001);
        chk("p3_done1", d1, 97);
        chk("p3_done2", d2, 196);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
